// File: rtl/fp_conv_pkg.sv
// Shared types and helpers for the signed-integer to small-float converters.
// Latency: none (package only).
// Backpressure: not applicable.
// Contents: FSM state enum, default widths, fp_pack() field packer for default widths.
package fp_conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fpState_e;

    localparam int DEF_IN_W  = 12;
    localparam int DEF_EXP_W = 3;
    localparam int DEF_MAN_W = 4;

    // Packs {sign, exp, man} for the default-width format.
    function automatic logic [DEF_EXP_W+DEF_MAN_W:0] fp_pack(
        input logic                 sign,
        input logic [DEF_EXP_W-1:0] exp,
        input logic [DEF_MAN_W-1:0] man
    );
        return {sign, exp, man};
    endfunction

endpackage

// File: rtl/fp_round.sv
// Round-half-up stage for a normalised mantissa, with carry into the exponent and clamping.
// Latency: combinational.
// Backpressure: none; the caller registers the outputs.
// Ports: man/rbit/exp in (kept mantissa, first dropped bit, exponent); manOut/expOut/sat out.
module fp_round
    import fp_conv_pkg::*;
#(
    parameter int EXP_W    = DEF_EXP_W,
    parameter int MAN_W    = DEF_MAN_W,
    parameter int ROUND_EN = 1
) (
    input  logic [MAN_W-1:0] man,
    input  logic             rbit,
    input  logic [EXP_W-1:0] exp,
    output logic [MAN_W-1:0] manOut,
    output logic [EXP_W-1:0] expOut,
    output logic             sat
);

    localparam logic [MAN_W-1:0] MAN_ONES  = '1;
    localparam logic [MAN_W-1:0] MAN_CARRY = {1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EXP_W-1:0] EXP_MAX   = '1;

    always_comb begin
        manOut = man;
        expOut = exp;
        sat    = 1'b0;
        if ((ROUND_EN != 0) && rbit) begin
            if (man != MAN_ONES) begin
                manOut = man + MAN_W'(1);
            end else if (exp != EXP_MAX) begin
                // Mantissa overflow: renormalise by one place into the exponent.
                manOut = MAN_CARRY;
                expOut = exp + EXP_W'(1);
            end else begin
                // No exponent headroom left: clamp to the largest code.
                sat = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_encoder_seq.sv
// Converts a signed IN_W-bit integer to {sign, exp, man} with an iterative one-bit-per-cycle normaliser.
// Latency: min(leading zeros of |in|, E_MAX) + 2 cycles from accept to out_valid.
// Backpressure: one word in flight; in_ready low until the result is taken by out_ready.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data; out_valid/out_ready/out_data/out_sat.
module fp_encoder_seq
    import fp_conv_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int EXP_W    = DEF_EXP_W,
    parameter int MAN_W    = DEF_MAN_W,
    parameter int ROUND_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic                   out_sat
);

    localparam int MAG_W = IN_W - 1;
    localparam int E_MAX = 2**EXP_W - 1;

    // The dropped-bit position and the exponent range only line up for this width relation.
    generate
        if (IN_W - 1 - MAN_W != 2**EXP_W - 1) begin : gIllegalWidths
            $error("fp_encoder_seq: IN_W-1-MAN_W must equal 2**EXP_W-1");
        end
    endgenerate

    fpState_e             state;
    logic [MAG_W-1:0]     magReg;
    logic [EXP_W-1:0]     expReg;
    logic                 signReg;
    logic                 satReg;
    logic                 inReadyReg;
    logic                 outValidReg;
    logic [EXP_W+MAN_W:0] outDataReg;
    logic                 outSatReg;

    // Input magnitude; the most negative value has no positive twin and clamps to all-ones.
    logic [IN_W-1:0]  negData;
    logic             isMostNeg;
    logic [MAG_W-1:0] magIn;

    assign negData   = -in_data;
    assign isMostNeg = in_data[IN_W-1] && (in_data[IN_W-2:0] == '0);
    assign magIn     = isMostNeg       ? '1 :
                       in_data[IN_W-1] ? negData[MAG_W-1:0] : in_data[MAG_W-1:0];

    logic [MAN_W-1:0] rndMan;
    logic [EXP_W-1:0] rndExp;
    logic             rndSat;

    fp_round #(
        .EXP_W    (EXP_W),
        .MAN_W    (MAN_W),
        .ROUND_EN (ROUND_EN)
    ) uRound (
        .man    (magReg[MAG_W-1 -: MAN_W]),
        .rbit   (magReg[MAG_W-1-MAN_W]),
        .exp    (expReg),
        .manOut (rndMan),
        .expOut (rndExp),
        .sat    (rndSat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            magReg      <= '0;
            expReg      <= '0;
            signReg     <= 1'b0;
            satReg      <= 1'b0;
            inReadyReg  <= 1'b1;
            outValidReg <= 1'b0;
            outDataReg  <= '0;
            outSatReg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        signReg    <= in_data[IN_W-1];
                        magReg     <= magIn;
                        satReg     <= isMostNeg;
                        expReg     <= EXP_W'(E_MAX);
                        inReadyReg <= 1'b0;
                        state      <= NORM;
                    end
                end
                NORM: begin
                    // Exponent floor at zero bounds the loop for zero and small inputs.
                    if (magReg[MAG_W-1] || (expReg == '0)) begin
                        state <= ROUND;
                    end else begin
                        magReg <= magReg << 1;
                        expReg <= expReg - EXP_W'(1);
                    end
                end
                ROUND: begin
                    outDataReg  <= {signReg, rndExp, rndMan};
                    outSatReg   <= satReg | rndSat;
                    outValidReg <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        outValidReg <= 1'b0;
                        inReadyReg  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    inReadyReg  <= 1'b1;
                    outValidReg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = inReadyReg;
    assign out_valid = outValidReg;
    assign out_data  = outDataReg;
    assign out_sat   = outSatReg;

endmodule
